ex_muldiv: RTL
==============

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have one clock and one reset: clk, input, 1, rising-edge clock; reset, input, 1, asynchronous, active-high.
REQ-002 The block SHALL have these further ports (name, direction, width, meaning):
  i_valid  input  1   EX-stage M-extension op present (from ID/EX control)
  i_op     input  3   0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
  i_A      input  32  rs1 operand (already forwarded)
  i_B      input  32  rs2 operand (already forwarded)
  i_rd     input  5   destination register index
  i_flush  input  1   pipeline flush (branch/jump redirect)
  o_stall  output 1   freeze PC, IF/ID and ID/EX; bubble EX/MEM
  o_done   output 1   one-cycle result-valid strobe
  o_result output 32  result, valid while o_done=1 and held afterwards
  o_rd     output 5   destination index captured at accept

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-004 Accept: in IDLE with i_valid=1 and i_flush=0, the block SHALL latch i_op, i_A, i_B and i_rd at the edge, clear the iteration counter, and enter BUSY.
REQ-005 BUSY SHALL perform one radix-2 iteration per edge: shift-add for MUL*, restoring shift-subtract for DIV*/REM*, using a 6-bit counter.
REQ-006 After the 32nd BUSY iteration the block SHALL enter DONE; DONE SHALL return to IDLE on the next edge.
REQ-007 Latency SHALL be fixed for every op and operand: o_done is high in the single cycle after the 33rd edge counted from the accept edge.
REQ-008 o_stall SHALL equal (IDLE and i_valid and not i_flush) or BUSY; it SHALL be combinational and low in DONE so the pipeline advances in that cycle.
REQ-009 o_done SHALL equal DONE and not i_flush.
REQ-010 Signed ops SHALL operate on magnitudes, with the sign of the result corrected in the final iteration; MULHSU treats i_A as signed and i_B as unsigned.
REQ-011 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32] of the 64-bit product.
REQ-012 Divide by zero SHALL give quotient 0xFFFFFFFF (DIV and DIVU) and remainder = dividend (REM and REMU), with the normal latency.
REQ-013 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give DIV = 0x80000000 and REM = 0.
REQ-014 i_flush in BUSY or DONE SHALL force IDLE at the next edge; no o_done is produced and o_result keeps its previous value.
REQ-015 i_valid while in BUSY or DONE SHALL be ignored.
REQ-016 i_valid and i_flush asserted together in IDLE SHALL not accept, and o_stall SHALL stay 0.
REQ-017 o_result and o_rd SHALL update only on entry to DONE, and SHALL hold until the next DONE or reset.
REQ-018 A new accept SHALL be possible in the cycle immediately after DONE (back-to-back throughput of one op every 34 cycles).

Reset
REQ-019 Asserting reset SHALL immediately force: state IDLE, counter 0, operand and accumulator registers 0, o_result 0, o_rd 0.
REQ-020 While reset is high, o_stall SHALL be 0 and o_done SHALL be 0.
REQ-021 Reset asserted mid-operation SHALL abandon the op; after release the block SHALL be in IDLE with no pending result.

Structure
REQ-022 The op encodings (OP_MUL..OP_REMU), the iteration count (32) and the FSM state encodings SHALL live in a shared package, muldiv_pkg.
REQ-023 The datapath SHALL be one 64-bit shift register plus one 33-bit adder/subtractor, shared by multiply and divide; a single module with no sub-module.
REQ-024 The EX-stage result mux SHALL select o_result when o_done=1, and the EX/MEM write-enable SHALL be gated by o_stall.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
  MUL 7 x -3 -> o_done in cycle accept+33, o_result 0xFFFFFFEB, o_stall high for exactly 33 cycles.
  MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100.
  DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
  Flush at accept+10 -> IDLE next edge, no o_done, o_result unchanged; then i_valid+i_flush together in IDLE -> no accept, o_stall 0.
  Reset at accept+20 -> all outputs 0 at once; a DIVU 9/3 issued after release -> 3 with full latency, o_rd = captured i_rd.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op encodings, iteration count and FSM states for the iterative
// RV32M multiply/divide unit.
package muldiv_pkg;
    localparam int unsigned ITERATIONS = 32;
    localparam int unsigned CNT_W      = 6;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic a_is_signed(input op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic b_is_signed(input op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction
endpackage

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide: one radix-2 step per clock on magnitudes,
// a single 64-bit shift register and one 33-bit adder shared by MUL* and DIV*.
module ex_muldiv
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_A,
    input  logic [31:0] i_B,
    input  logic [4:0]  i_rd,
    input  logic        i_flush,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_result,
    output logic [4:0]  o_rd
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_e              op_q, op_d;
    logic [63:0]      acc_q, acc_d;
    logic [31:0]      opnd_q, opnd_d;
    logic             neg_q, neg_d;
    logic [4:0]       rd_pend_q, rd_pend_d;
    logic [31:0]      result_q, result_d;
    logic [4:0]       rd_q, rd_d;

    op_e         in_op;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        accept;
    logic        div_mode;
    logic [32:0] add_a, add_b, add_sum;
    logic        add_co;
    logic [63:0] iter_val;
    logic [31:0] prod_hi_neg;
    logic [31:0] final_res;

    assign in_op  = op_e'(i_op);
    assign a_neg  = a_is_signed(in_op) & i_A[31];
    assign b_neg  = b_is_signed(in_op) & i_B[31];
    assign a_mag  = a_neg ? (~i_A + 32'd1) : i_A;
    assign b_mag  = b_neg ? (~i_B + 32'd1) : i_B;
    assign accept = (state_q == ST_IDLE) && i_valid && !i_flush;

    // Shared adder: add multiplicand to the upper half, or subtract the
    // divisor from the shifted partial remainder (carry-out = no borrow).
    assign div_mode = op_is_div(op_q);
    assign add_a    = div_mode ? acc_q[63:31] : {1'b0, acc_q[63:32]};
    assign add_b    = div_mode ? ~{1'b0, opnd_q} : {1'b0, opnd_q};
    assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {33'd0, div_mode};

    always_comb begin
        if (div_mode) begin
            iter_val = add_co ? {add_sum[31:0], acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
        end else begin
            iter_val = acc_q[0] ? {add_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
        end
    end

    // Upper half of the 64-bit two's complement: carry in only when the low half is zero.
    assign prod_hi_neg = ~iter_val[63:32] + {31'd0, (iter_val[31:0] == 32'd0)};

    always_comb begin
        final_res = iter_val[31:0];
        case (op_q)
            OP_MUL:                       final_res = iter_val[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = neg_q ? prod_hi_neg : iter_val[63:32];
            OP_DIV, OP_DIVU:              final_res = neg_q ? (~iter_val[31:0] + 32'd1) : iter_val[31:0];
            default:                      final_res = neg_q ? (~iter_val[63:32] + 32'd1) : iter_val[63:32];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_d     = neg_q;
        rd_pend_d = rd_pend_q;
        result_d  = result_q;
        rd_d      = rd_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_BUSY;
                    cnt_d     = '0;
                    op_d      = in_op;
                    rd_pend_d = i_rd;
                    if (op_is_div(in_op)) begin
                        acc_d  = {32'd0, a_mag};
                        opnd_d = b_mag;
                        // A zero divisor must yield an all-ones quotient, so no sign fix-up.
                        if ((in_op == OP_REM) || (in_op == OP_REMU)) begin
                            neg_d = a_neg;
                        end else begin
                            neg_d = (a_neg ^ b_neg) && (i_B != 32'd0);
                        end
                    end else begin
                        acc_d  = {32'd0, b_mag};
                        opnd_d = a_mag;
                        neg_d  = a_neg ^ b_neg;
                    end
                end
            end
            ST_BUSY: begin
                if (i_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = iter_val;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_d  = ST_DONE;
                        result_d = final_res;
                        rd_d     = rd_pend_q;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_MUL;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            rd_pend_q <= '0;
            result_q  <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            neg_q     <= neg_d;
            rd_pend_q <= rd_pend_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
        end
    end

    // Stall drops in DONE so the pipeline consumes the result that cycle.
    assign o_stall  = !reset && (accept || (state_q == ST_BUSY));
    assign o_done   = !reset && (state_q == ST_DONE) && !i_flush;
    assign o_result = result_q;
    assign o_rd     = rd_q;
endmodule
